// File: rtl/unidade_controle_multiciclo_pkg.sv
// controle_pkg: states, opcode/funct3 constants, ALU encodings and control word for the multi-cycle control unit
package controle_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;
  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH} kind_t;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_MEM = 3'b011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUBI = 3'b001;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGT = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGTU = 3'b111;
  localparam logic [1:0] ULA_SUB = 2'b00;
  localparam logic [1:0] ULA_ADD = 2'b01;
  localparam logic [1:0] ULA_EQ = 2'b10;
  localparam logic [1:0] ULA_MAG = 2'b11;
  typedef struct packed {
    kind_t kind;
    logic [1:0] op_ula;
    logic operation_type;
    logic ula_entry;
    logic branch;
    logic sign;
  } ctrl_t;
endpackage

// File: rtl/unidade_controle_multiciclo_decodificador.sv
// decodificador_controle: combinational decode of opcode/funct3/bit30 into a control word plus illegal flag
module decodificador_controle
  import controle_pkg::*;
(
  input logic [6:0] opcode,
  input logic [2:0] funct3,
  input logic alt,
  output ctrl_t cw,
  output logic illegal
);
  always_comb begin
    cw = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_STORE: begin
        cw.kind = opcode == OPC_LOAD ? K_LOAD : K_STORE;
        cw.op_ula = ULA_ADD;
        illegal = funct3 != F3_MEM;
      end
      OPC_OP: begin
        cw.kind = K_ALU;
        cw.op_ula = alt ? ULA_SUB : ULA_ADD;
        cw.operation_type = 1'b1;
        cw.ula_entry = 1'b1;
        illegal = funct3 != F3_ADD;
      end
      OPC_IMM: begin
        cw.kind = K_ALU;
        cw.op_ula = funct3 == F3_SUBI ? ULA_SUB : ULA_ADD;
        cw.operation_type = 1'b1;
        illegal = !(funct3 inside {F3_ADD, F3_SUBI});
      end
      OPC_BRANCH: begin
        cw.kind = K_BRANCH;
        cw.op_ula = funct3 inside {F3_BEQ, F3_BNE} ? ULA_EQ : ULA_MAG;
        cw.operation_type = 1'b1;
        cw.ula_entry = 1'b1;
        cw.branch = 1'b1;
        cw.sign = funct3 inside {F3_BLT, F3_BGT};
        illegal = !(funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGT, F3_BLTU, F3_BGTU});
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multi-cycle datapath sequencer with retire counter; CONTROLE_STEP_EN adds a step input gating FETCH
module unidade_controle_multiciclo
  import controle_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  input logic run,
`ifdef CONTROLE_STEP_EN
  input logic step,
`endif
  input logic [INSTR_W-1:0] instrucao,
  output logic load_en,
  output logic store_en,
  output logic [1:0] op_ula,
  output logic operation_type,
  output logic ula_entry,
  output logic branch,
  output logic sign,
  output logic pc_en,
  output logic halted,
  output logic illegal,
  output logic [CNT_W-1:0] instr_count
);
  state_t state, nxt;
  logic [INSTR_W-1:0] ir;
  ctrl_t cw, dec_cw;
  logic dec_illegal, go;
`ifdef CONTROLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  decodificador_controle u_dec (
    .opcode(ir[6:0]),
    .funct3(ir[14:12]),
    .alt(ir[30]),
    .cw(dec_cw),
    .illegal(dec_illegal)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = run ? FETCH : IDLE;
      FETCH: nxt = go ? DECODE : FETCH;
      DECODE: nxt = (ir == '0 || dec_illegal) ? HALT : EXECUTE;
      EXECUTE: nxt = cw.kind == K_BRANCH ? FETCH : cw.kind == K_ALU ? WRITEBACK : MEM;
      MEM: nxt = cw.kind == K_LOAD ? WRITEBACK : FETCH;
      WRITEBACK: nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  assign load_en = state == WRITEBACK;
  assign store_en = state == MEM && cw.kind == K_STORE;
  assign pc_en = load_en || store_en || (state == EXECUTE && cw.kind == K_BRANCH);
  assign halted = state == HALT;
  assign op_ula = cw.op_ula;
  assign operation_type = cw.operation_type;
  assign ula_entry = cw.ula_entry;
  assign branch = cw.branch;
  assign sign = cw.sign;
  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= '0;
      cw <= '0;
      illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == FETCH && go) ir <= instrucao;
      if (state == DECODE) cw <= nxt == HALT ? ctrl_t'('0) : dec_cw;
      else if (nxt == FETCH) cw <= '0;
      if (state == DECODE && nxt == HALT) illegal <= ir != '0;
      if (pc_en) instr_count <= instr_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: scoreboard bench for the multi-cycle control unit
module tb_unidade_controle_multiciclo;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic [31:0] instrucao = '0;
`ifdef CONTROLE_STEP_EN
  logic step = 1'b1;
`endif
  logic load_en, store_en, operation_type, ula_entry, branch, sign, pc_en, halted, illegal;
  logic [1:0] op_ula;
  logic [31:0] instr_count;
  typedef struct {
    int lat;
    logic ld;
    logic st;
    logic [1:0] op;
    logic ot;
    logic ue;
    logic br;
    logic sg;
    logic csg;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, fails = 0, cyc = 0;
  logic [31:0] retired = '0;
  always #5 clk = ~clk;
  unidade_controle_multiciclo dut (
    .clk(clk),
    .reset(reset),
    .run(run),
`ifdef CONTROLE_STEP_EN
    .step(step),
`endif
    .instrucao(instrucao),
    .load_en(load_en),
    .store_en(store_en),
    .op_ula(op_ula),
    .operation_type(operation_type),
    .ula_entry(ula_entry),
    .branch(branch),
    .sign(sign),
    .pc_en(pc_en),
    .halted(halted),
    .illegal(illegal),
    .instr_count(instr_count)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (pc_en || load_en || store_en) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: pc_en=%b load_en=%b store_en=%b expected no event", pc_en, load_en, store_en);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.lat);
        chk("pc_en", pc_en, 1);
        chk("load_en", load_en, e.ld);
        chk("store_en", store_en, e.st);
        chk("op_ula", op_ula, e.op);
        chk("operation_type", operation_type, e.ot);
        chk("ula_entry", ula_entry, e.ue);
        chk("branch", branch, e.br);
        if (e.csg) chk("sign", sign, e.sg);
        chk("instr_count", instr_count, e.cnt);
      end
    end
  end
  task automatic exec(input logic [31:0] ins, input int lat, input logic ld, input logic st,
                      input logic [1:0] op, input logic ot, input logic ue, input logic br,
                      input logic sg, input logic csg);
    int n;
    q.push_back('{lat, ld, st, op, ot, ue, br, sg, csg, retired});
    retired++;
    instrucao = ins;
    cyc = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    instrucao = 32'hFFFF_FFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pc_en && n < 8);
    chk("retire_seen", pc_en, 1);
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_load_en", load_en, 0);
    chk("rst_store_en", store_en, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_op_ula", op_ula, 0);
    chk("rst_ctrl", {operation_type, ula_entry, branch, sign}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_count", instr_count, 0);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    run = 1'b1;
    exec(32'h00F38FB3, 4, 1, 0, 2'b01, 1, 1, 0, 0, 1);
    run = 1'b0;
    exec(32'h00703083, 5, 1, 0, 2'b01, 0, 0, 0, 0, 1);
    exec(32'h03DE3423, 4, 0, 1, 2'b01, 0, 0, 0, 0, 1);
    exec(32'h40000033, 4, 1, 0, 2'b00, 1, 1, 0, 0, 1);
    exec(32'h00500093, 4, 1, 0, 2'b01, 1, 0, 0, 0, 1);
    exec(32'h00001093, 4, 1, 0, 2'b00, 1, 0, 0, 0, 1);
    exec(32'h00000063, 3, 0, 0, 2'b10, 1, 1, 1, 0, 0);
    exec(32'h00001063, 3, 0, 0, 2'b10, 1, 1, 1, 0, 0);
    exec(32'h00004063, 3, 0, 0, 2'b11, 1, 1, 1, 1, 1);
    exec(32'h00005063, 3, 0, 0, 2'b11, 1, 1, 1, 1, 1);
    exec(32'h00006063, 3, 0, 0, 2'b11, 1, 1, 1, 0, 1);
    exec(32'h00007063, 3, 0, 0, 2'b11, 1, 1, 1, 0, 1);
    instrucao = 32'hFE00007F;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("illegal_halted", halted, 1);
    chk("illegal_flag", illegal, 1);
    chk("halt_op_ula", op_ula, 0);
    repeat (10) @(negedge clk);
    chk("halt_absorbing", halted, 1);
    chk("halt_count", instr_count, 12);
    #1 reset = 1'b1;
    run = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    retired = '0;
    chk("rst2_count", instr_count, 0);
    chk("rst2_halted", halted, 0);
    chk("rst2_illegal", illegal, 0);
    instrucao = '0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("zero_halted", halted, 1);
    chk("zero_illegal", illegal, 0);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    exec(32'h00F38FB3, 4, 1, 0, 2'b01, 1, 1, 0, 0, 1);
    instrucao = 32'h00703083;
    repeat (4) @(negedge clk);
    chk("mem_store_en", store_en, 0);
    chk("mem_count", instr_count, 1);
    #1 reset = 1'b1;
    run = 1'b0;
    @(negedge clk); #1;
    chk("abort_load_en", load_en, 0);
    chk("abort_pc_en", pc_en, 0);
    chk("abort_count", instr_count, 0);
    chk("abort_op_ula", op_ula, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_pc_en", pc_en, 0);
    chk("idle_halted", halted, 0);
`ifdef CONTROLE_STEP_EN
    #1 retired = '0;
    step = 1'b0;
    instrucao = 32'h00F38FB3;
    run = 1'b1;
    q.push_back('{14, 1, 0, 2'b01, 1, 1, 0, 0, 1, 0});
    cyc = 0;
    repeat (10) @(negedge clk);
    chk("step_wait_pc_en", pc_en, 0);
    chk("step_wait_op_ula", op_ula, 0);
    #1 step = 1'b1;
    @(negedge clk); #1;
    step = 1'b0;
    repeat (8) @(negedge clk);
    chk("step_count", instr_count, 1);
`endif
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
